display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl_pkg.sv | 6 +
 rtl/display_scan_ctrl_dig_slot_timer.sv | 20 ++
 rtl/display_scan_ctrl.sv | 79 +++++++
 tb/tb_display_scan_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: shared FSM encoding and display constants for the digit scan controller.
package display_scan_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DEAD = 2'd1, S_ON = 2'd2} state_e;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam int NUM_DIGITS = 4;
endpackage

// File: rtl/display_scan_ctrl_dig_slot_timer.sv
// dig_slot_timer: free-running slot counter with synchronous clear and the two slot-boundary compares.
module dig_slot_timer #(
  parameter int P_DIV   = 50000,
  parameter int P_DEAD  = 500,
  parameter int P_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  output logic [P_CNT_W-1:0] cnt_o,
  output logic               dead_end_o,
  output logic               slot_end_o
);
  logic [P_CNT_W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (rst || clr_i) ? '0 : cnt_q + 1'b1;
  assign cnt_o      = cnt_q;
  assign dead_end_o = cnt_q == P_CNT_W'(P_DEAD - 1);
  assign slot_end_o = cnt_q == P_CNT_W'(P_DIV - 1);
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit scan FSM with per-slot dead time and optional leading-zero blanking.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int P_DIV   = 50000,
  parameter int P_DEAD  = 500,
  parameter int P_CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       blank_lz,
  input  logic [3:0] ent0,
  input  logic [3:0] ent1,
  input  logic [3:0] ent2,
  input  logic [3:0] ent3,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       slot_tick
);
  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         lz_q, lz_d, lz_new;
  logic               l3, l2, l1;
  logic               clr, dead_end, slot_end;
  logic [P_CNT_W-1:0] cnt;

  dig_slot_timer #(.P_DIV(P_DIV), .P_DEAD(P_DEAD), .P_CNT_W(P_CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .cnt_o      (cnt),
    .dead_end_o (dead_end),
    .slot_end_o (slot_end)
  );

  always_comb begin
    l3      = ent3 == 4'd0;
    l2      = l3 && ent2 == 4'd0;
    l1      = l2 && ent1 == 4'd0;
    lz_new  = blank_lz ? {l3, l2, l1, 1'b0} : 4'b0000;
    state_d = state_q;
    sel_d   = sel_q;
    lz_d    = lz_q;
    clr     = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      clr     = 1'b1;
    end else if (state_q == S_IDLE) begin
      state_d = S_DEAD;
      clr     = 1'b1;
      lz_d    = lz_new;
    end else if (state_q == S_DEAD) begin
      state_d = dead_end ? S_ON : S_DEAD;
    end else if (slot_end) begin
      // sel advances only as the next dead time begins, so the mux settles while dark
      state_d = S_DEAD;
      clr     = 1'b1;
      sel_d   = sel_q + 2'd1;
      lz_d    = lz_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      lz_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lz_q    <= lz_d;
    end
  end

  assign sel       = sel_q;
  assign an        = (state_q == S_ON && !lz_q[sel_q]) ? ~(4'b0001 << sel_q) : AN_OFF;
  assign slot_tick = state_q == S_ON && slot_end;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed plus random stimulus against a time-based scan reference model.
module tb_display_scan_ctrl;
  localparam int P_DIV = 8;
  localparam int P_DEAD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       blank_lz = 1'b0;
  logic [3:0] ent [4];
  logic [1:0] sel;
  logic [3:0] an;
  logic       slot_tick;

  int passed = 0;
  int total = 0;

  bit         m_act = 1'b0;
  int         m_t = 0;
  int         m_base = 0;
  logic [3:0] m_mask = 4'b0000;

  always #5 clk = ~clk;

  display_scan_ctrl #(.P_DIV(P_DIV), .P_DEAD(P_DEAD), .P_CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .blank_lz  (blank_lz),
    .ent0      (ent[0]),
    .ent1      (ent[1]),
    .ent2      (ent[2]),
    .ent3      (ent[3]),
    .sel       (sel),
    .an        (an),
    .slot_tick (slot_tick)
  );

  function automatic int cur_slot();
    return (m_base + m_t / P_DIV) % 4;
  endfunction

  function automatic logic [3:0] lz_capture();
    logic [3:0] m = 4'b0000;
    if (blank_lz)
      for (int i = 3; i >= 1; i--) begin
        if (ent[i] != 4'd0) break;
        m[i] = 1'b1;
      end
    return m;
  endfunction

  function automatic bit is_on(int s);
    return m_act && cur_slot() == s && (m_t % P_DIV) >= P_DEAD;
  endfunction

  task automatic check(string tag, int got, int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    int s, pos;
    logic [3:0] e_an;
    @(posedge clk);
    if (rst) begin
      m_act = 1'b0; m_t = 0; m_base = 0; m_mask = 4'b0000;
    end else if (!en) begin
      if (m_act) m_base = cur_slot();
      m_act = 1'b0; m_t = 0;
    end else if (!m_act) begin
      m_act = 1'b1; m_t = 0; m_mask = lz_capture();
    end else begin
      m_t++;
      if (m_t % P_DIV == 0) m_mask = lz_capture();
    end
    #1;
    s = cur_slot();
    pos = m_t % P_DIV;
    e_an = (!m_act || pos < P_DEAD || m_mask[s]) ? 4'b1111 : ~(4'b0001 << s);
    check("sel", int'(sel), s);
    check("an", int'(an), int'(e_an));
    check("slot_tick", int'(slot_tick), int'(m_act && pos == P_DIV - 1));
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_on(int s);
    for (int i = 0; i < 64 && !is_on(s); i++) step();
    check("reach_on_slot", int'(is_on(s)), 1);
  endtask

  initial begin
    ent[0] = 4'd1; ent[1] = 4'd2; ent[2] = 4'd3; ent[3] = 4'd4;
    steps(2);
    check("reset_an", int'(an), 4'hF);
    rst = 1'b0;
    steps(1 + 32 + 8);
    blank_lz = 1'b1;
    ent[3] = 4'd0; ent[2] = 4'd0; ent[1] = 4'd5; ent[0] = 4'd0;
    steps(40);
    ent[1] = 4'd0;
    steps(8);
    run_until_on(3);
    ent[3] = 4'd7;
    steps(40);
    run_until_on(2);
    en = 1'b0;
    step();
    check("en_off_sel_held", int'(sel), 2);
    steps(2);
    en = 1'b1;
    steps(12);
    run_until_on(3);
    rst = 1'b1;
    step();
    check("rst_mid_on_sel", int'(sel), 0);
    rst = 1'b0;
    steps(6);
    check("after_rst_digit0_lit", int'(an), 4'hE);
    for (int i = 0; i < 500; i++) begin
      en = ($urandom % 16) != 0;
      rst = ($urandom % 64) == 0;
      if ($urandom % 16 == 0) blank_lz = $urandom % 2;
      for (int d = 0; d < 4; d++)
        if ($urandom % 8 == 0) ent[d] = ($urandom % 3 == 0) ? 4'($urandom) : 4'd0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
